// File: rtl/stepped_core_pkg.sv
// Shared types and instruction-field helpers for the stepped_core processor.
// The helpers work on 32-bit containers so callers can slice to any parametrised width.
package stepped_core_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_STORE = 2'b10,
    OP_BEQZ  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } state_e;

  function automatic logic [31:0] get_field(input logic [31:0] word, input int lsb,
                                            input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (word >> lsb) & mask;
  endfunction

  // Replicates bit (width-1) of value into all higher bits of the 32-bit result.
  function automatic logic [31:0] sign_ext(input logic [31:0] value, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    if (value[width-1]) return value | ~mask;
    else                return value & mask;
  endfunction

endpackage

// File: rtl/stepped_core_dmem.sv
// Data memory: one combinational read port, one synchronous write port.
// Reset loads a ramp 0..N/2-1 in the lower half and 0,-1,-2,... in the upper half.
module stepped_core_dmem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i < DEPTH / 2) ? DATA_W'(i) : DATA_W'(DEPTH / 2 - i);
      end
    end else if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stepped_core.sv
// Multi-cycle register processor: IDLE -> FETCH (valid handshake) -> EXEC per step_en.
// Strobes decode from the state register and the latched instruction only.
module stepped_core
  import stepped_core_pkg::*;
#(
  parameter  int DATA_W     = 8,
  parameter  int REG_COUNT  = 4,
  parameter  int DMEM_DEPTH = 32,
  parameter  int PC_W       = 8,
  localparam int RSEL_W     = $clog2(REG_COUNT),
  localparam int DADDR_W    = $clog2(DMEM_DEPTH),
  localparam int INSTR_W    = 2 + 3 * RSEL_W
) (
  input  logic               oscillator,
  input  logic               reset,
  input  logic               step_en,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_address,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  output logic [1:0]         op,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               retired,
  input  logic [RSEL_W-1:0]  dbg_sel,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e              r_state;
  state_e              w_next_state;
  logic [PC_W-1:0]     r_pc;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_regs [REG_COUNT];

  op_e                 w_op;
  logic [RSEL_W-1:0]   w_a;
  logic [RSEL_W-1:0]   w_b;
  logic [RSEL_W-1:0]   w_c;
  logic [DATA_W-1:0]   w_imm_d;
  logic [PC_W-1:0]     w_imm_pc;
  logic [DADDR_W-1:0]  w_dmem_addr;
  logic [DATA_W-1:0]   w_rdata;
  logic [DATA_W-1:0]   w_store_data;
  logic [DATA_W-1:0]   w_wr_data;
  logic [RSEL_W-1:0]   w_dst;
  logic                w_taken;
  logic [PC_W-1:0]     w_next_pc;

  assign w_op     = op_e'(r_ir[INSTR_W-1 -: 2]);
  assign w_a      = RSEL_W'(get_field(32'(r_ir), 2 * RSEL_W, RSEL_W));
  assign w_b      = RSEL_W'(get_field(32'(r_ir), RSEL_W, RSEL_W));
  assign w_c      = RSEL_W'(get_field(32'(r_ir), 0, RSEL_W));
  assign w_imm_d  = DATA_W'(sign_ext(32'(w_c), RSEL_W));
  assign w_imm_pc = PC_W'(sign_ext(32'(w_c), RSEL_W));

  // Only the low address bits of the full-width sum select the word.
  assign w_dmem_addr  = DADDR_W'(r_regs[w_a] + w_imm_d);
  assign w_store_data = r_regs[w_b];
  assign w_wr_data    = (w_op == OP_ADD) ? (r_regs[w_a] + r_regs[w_b]) : w_rdata;
  assign w_dst        = (w_op == OP_ADD) ? w_c : w_b;
  assign w_taken      = (w_op == OP_BEQZ) && (r_regs[w_a] == '0);
  assign w_next_pc    = r_pc + PC_W'(1) + (w_taken ? w_imm_pc : '0);

  stepped_core_dmem #(
    .DATA_W (DATA_W),
    .DEPTH  (DMEM_DEPTH)
  ) u_dmem (
    .i_clk     (oscillator),
    .i_rst     (reset),
    .i_rd_addr (w_dmem_addr),
    .o_rd_data (w_rdata),
    .i_we      (mem_write),
    .i_wr_addr (w_dmem_addr),
    .i_wr_data (w_store_data)
  );

  always_ff @(posedge oscillator) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_FETCH && instr_valid) r_ir <= instruction;
      if (r_state == S_EXEC) begin
        r_pc <= w_next_pc;
        if (reg_write) r_regs[w_dst] <= w_wr_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    instr_req    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    retired      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (step_en) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        instr_req = 1'b1;
        if (instr_valid) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        retired      = 1'b1;
        reg_write    = (w_op == OP_ADD) || (w_op == OP_LOAD);
        mem_read     = (w_op == OP_LOAD);
        mem_write    = (w_op == OP_STORE);
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign instr_address = r_pc;
  assign op            = r_ir[INSTR_W-1 -: 2];
  assign dbg_data      = r_regs[dbg_sel];

endmodule

// File: tb/tb_stepped_core.sv
// Bench for stepped_core at default parameters, checked against an array-based
// instruction-level model of registers, data memory and pc.
module tb_stepped_core;

  logic       oscillator = 1'b0;
  logic       reset;
  logic       step_en;
  logic       instr_req;
  logic [7:0] instr_address;
  logic [7:0] instruction;
  logic       instr_valid;
  logic [1:0] op;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       retired;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int m_regs [4];
  int m_dmem [32];
  int m_pc;

  stepped_core dut (
    .oscillator    (oscillator),
    .reset         (reset),
    .step_en       (step_en),
    .instr_req     (instr_req),
    .instr_address (instr_address),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .op            (op),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .retired       (retired),
    .dbg_sel       (dbg_sel),
    .dbg_data      (dbg_data)
  );

  always #5 oscillator = ~oscillator;
  always @(posedge oscillator) cyc <= cyc + 1;

  function automatic void model_reset();
    m_pc = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    for (int i = 0; i < 32; i++) m_dmem[i] = (i < 16) ? i : (256 - (i - 16)) % 256;
  endfunction

  function automatic void model_step(input logic [7:0] ins);
    int o, a, b, c, imm, addr;
    o    = int'(ins[7:6]);
    a    = int'(ins[5:4]);
    b    = int'(ins[3:2]);
    c    = int'(ins[1:0]);
    imm  = (c >= 2) ? c - 4 : c;
    addr = (m_regs[a] + imm + 256) % 32;
    case (o)
      0: m_regs[c] = (m_regs[a] + m_regs[b]) % 256;
      1: m_regs[b] = m_dmem[addr];
      2: m_dmem[addr] = m_regs[b];
      default: ;
    endcase
    if (o == 3 && m_regs[a] == 0) m_pc = (m_pc + 1 + imm + 256) % 256;
    else                          m_pc = (m_pc + 1) % 256;
  endfunction

  task automatic read_reg(input int i, output logic [7:0] v);
    dbg_sel = 2'(i);
    #1;
    v = dbg_data;
  endtask

  task automatic apply_reset();
    @(negedge oscillator);
    reset = 1'b1;
    repeat (2) @(negedge oscillator);
    reset = 1'b0;
    model_reset();
  endtask

  // One instruction with immediate instr_valid; ends in IDLE with updates visible.
  task automatic run_instr(input logic [7:0] ins, output int lat, output int n_rd,
                           output int n_wr, output int n_rw, output int n_ret);
    int s;
    lat = -1; n_rd = 0; n_wr = 0; n_rw = 0; n_ret = 0;
    @(negedge oscillator);
    s = cyc;
    step_en = 1'b1;
    instruction = ins;
    instr_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge oscillator);
      step_en = 1'b0;
      if (mem_read)  n_rd++;
      if (mem_write) n_wr++;
      if (reg_write) n_rw++;
      if (retired) begin
        n_ret++;
        if (lat < 0) lat = cyc - s;
      end
    end
    instr_valid = 1'b0;
    model_step(ins);
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1'b1; step_en = 1'b0; instr_valid = 1'b0; instruction = 8'h00; dbg_sel = 2'd0;
    repeat (3) @(negedge oscillator);
    n_cmp++; if (instr_req !== 1'b0) begin n_err++; $display("FAIL reset_instr_req: got %b want 0", instr_req); end
    n_cmp++; if (instr_address !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h want 00", instr_address); end
    n_cmp++; if (op !== 2'b00) begin n_err++; $display("FAIL reset_op: got %b want 00", op); end
    n_cmp++; if ({mem_read, mem_write, reg_write, retired} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, reg_write, retired});
    end
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00", i, v); end
    end
  endtask

  task automatic test_load();
    int lat, rd, wr, rw, ret;
    logic [7:0] v;
    run_instr(8'h45, lat, rd, wr, rw, ret);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL load_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 1 || rw !== 1 || wr !== 0 || ret !== 1) begin
      n_err++; $display("FAIL load_strobes: rd=%0d wr=%0d rw=%0d ret=%0d want 1 0 1 1", rd, wr, rw, ret);
    end
    n_cmp++; if (instr_address !== 8'd1) begin n_err++; $display("FAIL load_pc: got %h want 01", instr_address); end
    read_reg(1, v);
    n_cmp++; if (v !== 8'd1) begin n_err++; $display("FAIL load_r1: got %h want 01", v); end
  endtask

  task automatic test_add();
    int lat, rd, wr, rw, ret;
    logic [7:0] v;
    run_instr(8'h16, lat, rd, wr, rw, ret);
    read_reg(2, v);
    n_cmp++; if (v !== 8'd2) begin n_err++; $display("FAIL add_r2: got %h want 02", v); end
    n_cmp++; if (rd !== 0 || rw !== 1 || wr !== 0) begin
      n_err++; $display("FAIL add_strobes: rd=%0d wr=%0d rw=%0d want 0 0 1", rd, wr, rw);
    end
  endtask

  task automatic test_store_wrap();
    int lat, rd, wr, rw, ret;
    logic [7:0] v;
    run_instr(8'h8B, lat, rd, wr, rw, ret);
    n_cmp++; if (wr !== 1 || rw !== 0 || rd !== 0) begin
      n_err++; $display("FAIL store_strobes: rd=%0d wr=%0d rw=%0d want 0 1 0", rd, wr, rw);
    end
    run_instr(8'h4F, lat, rd, wr, rw, ret);
    read_reg(3, v);
    n_cmp++; if (v !== 8'd2) begin n_err++; $display("FAIL store_reload_r3: got %h want 02", v); end
  endtask

  task automatic test_add_wrap();
    int lat, rd, wr, rw, ret;
    logic [7:0] v;
    for (int i = 0; i < 3; i++) run_instr(8'h2A, lat, rd, wr, rw, ret);
    run_instr(8'h6D, lat, rd, wr, rw, ret);
    read_reg(3, v);
    n_cmp++; if (v !== 8'hFF) begin n_err++; $display("FAIL wrap_load_r3: got %h want ff", v); end
    run_instr(8'h37, lat, rd, wr, rw, ret);
    read_reg(3, v);
    n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL wrap_add_r3: got %h want 00", v); end
  endtask

  task automatic test_beqz();
    int lat, rd, wr, rw, ret;
    apply_reset();
    for (int i = 0; i < 5; i++) run_instr(8'h00, lat, rd, wr, rw, ret);
    n_cmp++; if (instr_address !== 8'd5) begin n_err++; $display("FAIL beqz_setup_pc: got %h want 05", instr_address); end
    run_instr(8'hC2, lat, rd, wr, rw, ret);
    n_cmp++; if (instr_address !== 8'd4) begin n_err++; $display("FAIL beqz_taken_pc: got %h want 04", instr_address); end
    n_cmp++; if (rd !== 0 || wr !== 0 || rw !== 0 || ret !== 1) begin
      n_err++; $display("FAIL beqz_strobes: rd=%0d wr=%0d rw=%0d ret=%0d want 0 0 0 1", rd, wr, rw, ret);
    end
    run_instr(8'h45, lat, rd, wr, rw, ret);
    run_instr(8'hD2, lat, rd, wr, rw, ret);
    n_cmp++; if (instr_address !== 8'd6) begin n_err++; $display("FAIL beqz_not_taken_pc: got %h want 06", instr_address); end
    for (int i = 0; i < 124; i++) run_instr(8'hC1, lat, rd, wr, rw, ret);
    run_instr(8'h00, lat, rd, wr, rw, ret);
    n_cmp++; if (instr_address !== 8'hFF) begin n_err++; $display("FAIL beqz_climb_pc: got %h want ff", instr_address); end
    run_instr(8'hD2, lat, rd, wr, rw, ret);
    n_cmp++; if (instr_address !== 8'h00) begin n_err++; $display("FAIL beqz_wrap_pc: got %h want 00", instr_address); end
  endtask

  task automatic test_stall();
    logic [7:0] addr0, v;
    int ret_cnt;
    @(negedge oscillator);
    step_en = 1'b1; instr_valid = 1'b0; instruction = 8'h16;
    @(negedge oscillator);
    step_en = 1'b0;
    addr0 = instr_address;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (instr_req !== 1'b1) begin n_err++; $display("FAIL stall_req c%0d: got %b want 1", k, instr_req); end
      n_cmp++; if (instr_address !== addr0) begin n_err++; $display("FAIL stall_addr c%0d: got %h want %h", k, instr_address, addr0); end
      n_cmp++; if ({mem_read, mem_write, reg_write, retired} !== 4'b0000) begin
        n_err++; $display("FAIL stall_strobes c%0d: got %b want 0000", k, {mem_read, mem_write, reg_write, retired});
      end
      step_en = (k == 2);
      @(negedge oscillator);
    end
    read_reg(2, v);
    n_cmp++; if (v !== 8'(m_regs[2])) begin n_err++; $display("FAIL stall_r2_held: got %h want %h", v, 8'(m_regs[2])); end
    instr_valid = 1'b1;
    ret_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge oscillator);
      instr_valid = 1'b0;
      if (retired) ret_cnt++;
    end
    model_step(8'h16);
    n_cmp++; if (ret_cnt !== 1) begin n_err++; $display("FAIL stall_retire_count: got %0d want 1", ret_cnt); end
    n_cmp++; if (instr_req !== 1'b0) begin n_err++; $display("FAIL stall_no_requeue: got %b want 0", instr_req); end
    read_reg(2, v);
    n_cmp++; if (v !== 8'd2) begin n_err++; $display("FAIL stall_r2_after: got %h want 02", v); end
    n_cmp++; if (instr_address !== 8'(m_pc)) begin n_err++; $display("FAIL stall_pc: got %h want %h", instr_address, 8'(m_pc)); end
  endtask

  task automatic test_reset_mid();
    int lat, rd, wr, rw, ret;
    logic [7:0] v;
    @(negedge oscillator);
    step_en = 1'b1; instr_valid = 1'b0;
    @(negedge oscillator);
    step_en = 1'b0;
    reset = 1'b1;
    @(negedge oscillator);
    reset = 1'b0;
    model_reset();
    n_cmp++; if (instr_req !== 1'b0) begin n_err++; $display("FAIL midfetch_req: got %b want 0", instr_req); end
    n_cmp++; if (instr_address !== 8'h00) begin n_err++; $display("FAIL midfetch_pc: got %h want 00", instr_address); end
    run_instr(8'h45, lat, rd, wr, rw, ret);
    run_instr(8'h16, lat, rd, wr, rw, ret);
    @(negedge oscillator);
    step_en = 1'b1; instruction = 8'h8B; instr_valid = 1'b1;
    @(negedge oscillator);
    step_en = 1'b0;
    @(negedge oscillator);
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL midexec_in_exec: got %b want 1", mem_write); end
    reset = 1'b1;
    instr_valid = 1'b0;
    @(negedge oscillator);
    reset = 1'b0;
    model_reset();
    n_cmp++; if (instr_req !== 1'b0 || retired !== 1'b0) begin
      n_err++; $display("FAIL midexec_ctrl: req=%b ret=%b want 0 0", instr_req, retired);
    end
    n_cmp++; if (instr_address !== 8'h00) begin n_err++; $display("FAIL midexec_pc: got %h want 00", instr_address); end
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      n_cmp++; if (v !== 8'h00) begin n_err++; $display("FAIL midexec_reg%0d: got %h want 00", i, v); end
    end
    run_instr(8'h4F, lat, rd, wr, rw, ret);
    read_reg(3, v);
    n_cmp++; if (v !== 8'hF1) begin n_err++; $display("FAIL midexec_dmem31: got %h want f1", v); end
  endtask

  task automatic test_random();
    int lat, rd, wr, rw, ret;
    logic [7:0] ins, v;
    for (int n = 0; n < 60; n++) begin
      ins = 8'($urandom);
      run_instr(ins, lat, rd, wr, rw, ret);
      n_cmp++; if (lat !== 2 || ret !== 1) begin
        n_err++; $display("FAIL rand%0d_retire ins=%h: lat=%0d ret=%0d want 2 1", n, ins, lat, ret);
      end
      n_cmp++; if (rd !== int'(ins[7:6] == 2'b01) || wr !== int'(ins[7:6] == 2'b10) ||
                   rw !== int'(ins[7:6] == 2'b00 || ins[7:6] == 2'b01)) begin
        n_err++; $display("FAIL rand%0d_strobes ins=%h: rd=%0d wr=%0d rw=%0d", n, ins, rd, wr, rw);
      end
      n_cmp++; if (instr_address !== 8'(m_pc)) begin
        n_err++; $display("FAIL rand%0d_pc ins=%h: got %h want %h", n, ins, instr_address, 8'(m_pc));
      end
      for (int i = 0; i < 4; i++) begin
        read_reg(i, v);
        n_cmp++; if (v !== 8'(m_regs[i])) begin
          n_err++; $display("FAIL rand%0d_r%0d ins=%h: got %h want %h", n, i, ins, v, 8'(m_regs[i]));
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_add();
    test_store_wrap();
    test_add_wrap();
    test_beqz();
    test_stall();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
